// File: rtl/speicher_arbiter.sv
// Shares one single-port RAM between instruction fetch and data port, and
// decodes the I/O window (data address bit 31) so I/O never reaches the RAM.
module speicher_arbiter #(
  parameter int unsigned ADRESSBREITE = 8,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    LeseInstruktion,
  input  logic [31:0]             InstruktionAdresse,
  output logic [31:0]             Instruktion,
  output logic                    InstruktionGeladen,
  input  logic                    LeseDaten,
  input  logic                    SchreibeDaten,
  input  logic [31:0]             DatenAdresse,
  input  logic [31:0]             DatenRaus,
  output logic [31:0]             DatenRein,
  output logic                    DatenGeladen,
  output logic                    DatenGespeichert,
  output logic                    Fehler,
  output logic                    RAMLesenAn,
  output logic                    RAMSchreibenAn,
  output logic [ADRESSBREITE-1:0] RAMAdresse,
  output logic [31:0]             RAMDatenRein,
  input  logic [31:0]             RAMDatenRaus,
  input  logic                    RAMDatenBereit,
  input  logic                    RAMDatenGeschrieben,
  output logic [7:0]              IOAusgabe,
  input  logic [7:0]              IOEingang
);

  localparam int unsigned ZAEHLERBREITE = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {RUHE, INSTR, DLESEN, DSCHREIBEN, FERTIG} zustandTyp;

  zustandTyp                zustand, zustandNext;
  logic                     letzterDaten, letzterDatenNext;
  logic                     bedienteDaten, bedienteDatenNext;
  logic [ZAEHLERBREITE-1:0] zaehler, zaehlerNext;
  logic [31:0]              instruktionNext, datenReinNext, ramDatenReinNext;
  logic [7:0]               ioAusgabeNext;
  logic [ADRESSBREITE-1:0]  ramAdresseNext;
  logic                     ramLesenNext, ramSchreibenNext;
  logic                     instruktionGeladenNext, datenGeladenNext;
  logic                     datenGespeichertNext, fehlerNext;
  logic                     waehleDaten, timeoutErreicht;
  logic                     unusedBits;

  // Data wins if it is the only request or if instruction was served last.
  assign waehleDaten     = (LeseDaten || SchreibeDaten) && (!LeseInstruktion || !letzterDaten);
  assign timeoutErreicht = (TIMEOUT != 0) && (zaehler == ZAEHLERBREITE'(1));
  assign unusedBits      = ^{InstruktionAdresse[31:ADRESSBREITE], DatenAdresse[30:ADRESSBREITE]};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      zustand            <= RUHE;
      letzterDaten       <= 1'b1;
      bedienteDaten      <= 1'b0;
      zaehler            <= '0;
      Instruktion        <= '0;
      InstruktionGeladen <= 1'b0;
      DatenRein          <= '0;
      DatenGeladen       <= 1'b0;
      DatenGespeichert   <= 1'b0;
      Fehler             <= 1'b0;
      RAMLesenAn         <= 1'b0;
      RAMSchreibenAn     <= 1'b0;
      RAMAdresse         <= '0;
      RAMDatenRein       <= '0;
      IOAusgabe          <= '0;
    end else begin
      zustand            <= zustandNext;
      letzterDaten       <= letzterDatenNext;
      bedienteDaten      <= bedienteDatenNext;
      zaehler            <= zaehlerNext;
      Instruktion        <= instruktionNext;
      InstruktionGeladen <= instruktionGeladenNext;
      DatenRein          <= datenReinNext;
      DatenGeladen       <= datenGeladenNext;
      DatenGespeichert   <= datenGespeichertNext;
      Fehler             <= fehlerNext;
      RAMLesenAn         <= ramLesenNext;
      RAMSchreibenAn     <= ramSchreibenNext;
      RAMAdresse         <= ramAdresseNext;
      RAMDatenRein       <= ramDatenReinNext;
      IOAusgabe          <= ioAusgabeNext;
    end
  end

  always_comb begin
    zustandNext            = zustand;
    letzterDatenNext       = letzterDaten;
    bedienteDatenNext      = bedienteDaten;
    zaehlerNext            = zaehler;
    instruktionNext        = Instruktion;
    datenReinNext          = DatenRein;
    ioAusgabeNext          = IOAusgabe;
    ramAdresseNext         = RAMAdresse;
    ramDatenReinNext       = RAMDatenRein;
    ramLesenNext           = RAMLesenAn;
    ramSchreibenNext       = RAMSchreibenAn;
    instruktionGeladenNext = 1'b0;
    datenGeladenNext       = 1'b0;
    datenGespeichertNext   = 1'b0;
    fehlerNext             = 1'b0;

    case (zustand)
      RUHE: begin
        if (waehleDaten) begin
          bedienteDatenNext = 1'b1;
          if (DatenAdresse[31]) begin
            // I/O window: completes without touching the RAM.
            zustandNext = FERTIG;
            if (SchreibeDaten) begin
              ioAusgabeNext        = DatenRaus[7:0];
              datenGespeichertNext = 1'b1;
            end else begin
              datenReinNext    = {24'b0, IOEingang};
              datenGeladenNext = 1'b1;
            end
          end else begin
            ramAdresseNext = DatenAdresse[ADRESSBREITE-1:0];
            zaehlerNext    = ZAEHLERBREITE'(TIMEOUT);
            if (SchreibeDaten) begin
              ramDatenReinNext = DatenRaus;
              ramSchreibenNext = 1'b1;
              zustandNext      = DSCHREIBEN;
            end else begin
              ramLesenNext = 1'b1;
              zustandNext  = DLESEN;
            end
          end
        end else if (LeseInstruktion) begin
          bedienteDatenNext = 1'b0;
          ramAdresseNext    = InstruktionAdresse[ADRESSBREITE-1:0];
          zaehlerNext       = ZAEHLERBREITE'(TIMEOUT);
          ramLesenNext      = 1'b1;
          zustandNext       = INSTR;
        end
      end

      INSTR, DLESEN: begin
        if (RAMDatenBereit || timeoutErreicht) begin
          ramLesenNext = 1'b0;
          zustandNext  = FERTIG;
          fehlerNext   = !RAMDatenBereit;
          if (zustand == INSTR) begin
            instruktionNext        = RAMDatenBereit ? RAMDatenRaus : 32'b0;
            instruktionGeladenNext = 1'b1;
          end else begin
            datenReinNext    = RAMDatenBereit ? RAMDatenRaus : 32'b0;
            datenGeladenNext = 1'b1;
          end
        end else begin
          zaehlerNext = zaehler - ZAEHLERBREITE'(1);
        end
      end

      DSCHREIBEN: begin
        if (RAMDatenGeschrieben || timeoutErreicht) begin
          ramSchreibenNext     = 1'b0;
          zustandNext          = FERTIG;
          fehlerNext           = !RAMDatenGeschrieben;
          datenGespeichertNext = 1'b1;
        end else begin
          zaehlerNext = zaehler - ZAEHLERBREITE'(1);
        end
      end

      FERTIG: begin
        // Stale request of the served port is never seen in RUHE.
        letzterDatenNext = bedienteDaten;
        zustandNext      = RUHE;
      end

      default: zustandNext = RUHE;
    endcase
  end

endmodule

// File: tb/tb_speicher_arbiter.sv
// Bench for speicher_arbiter: directed vector table, hand-written arbitration
// and reset sequences, then random rounds against a transaction-level model.
module tb_speicher_arbiter;

  localparam int unsigned AB = 8;
  localparam int unsigned TO = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          LeseInstruktion = 1'b0;
  logic [31:0]   InstruktionAdresse = '0;
  logic [31:0]   Instruktion;
  logic          InstruktionGeladen;
  logic          LeseDaten = 1'b0;
  logic          SchreibeDaten = 1'b0;
  logic [31:0]   DatenAdresse = '0;
  logic [31:0]   DatenRaus = '0;
  logic [31:0]   DatenRein;
  logic          DatenGeladen;
  logic          DatenGespeichert;
  logic          Fehler;
  logic          RAMLesenAn;
  logic          RAMSchreibenAn;
  logic [AB-1:0] RAMAdresse;
  logic [31:0]   RAMDatenRein;
  logic [31:0]   RAMDatenRaus = '0;
  logic          RAMDatenBereit = 1'b0;
  logic          RAMDatenGeschrieben = 1'b0;
  logic [7:0]    IOAusgabe;
  logic [7:0]    IOEingang = '0;

  speicher_arbiter #(.ADRESSBREITE(AB), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .LeseInstruktion(LeseInstruktion), .InstruktionAdresse(InstruktionAdresse),
    .Instruktion(Instruktion), .InstruktionGeladen(InstruktionGeladen),
    .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten),
    .DatenAdresse(DatenAdresse), .DatenRaus(DatenRaus), .DatenRein(DatenRein),
    .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert), .Fehler(Fehler),
    .RAMLesenAn(RAMLesenAn), .RAMSchreibenAn(RAMSchreibenAn), .RAMAdresse(RAMAdresse),
    .RAMDatenRein(RAMDatenRein), .RAMDatenRaus(RAMDatenRaus),
    .RAMDatenBereit(RAMDatenBereit), .RAMDatenGeschrieben(RAMDatenGeschrieben),
    .IOAusgabe(IOAusgabe), .IOEingang(IOEingang)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // RAM behaviour: ack after ramLatenz command cycles, or never.
  logic [31:0] ramMem [256];
  int          ramLatenz = 0;
  bit          ramNie = 1'b0;
  int          ramWarte = 0;

  // Reference model state.
  logic [31:0] refMem [256];
  logic [7:0]  refIO = '0;
  bit          modelLetzterDaten = 1'b1;

  typedef struct {
    bit          instr;
    bit          lies;
    bit          schreib;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          lat;
    logic [7:0]  ioIn;
    int          expTyp;
    int          expN;
    int          expCmd;
    logic [31:0] expWert;
    bit          expFe;
    logic [7:0]  expIO;
  } tbVektor;

  tbVektor vek [9];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pruefe(input string name, input logic [31:0] ist, input logic [31:0] soll);
    tests++;
    if (ist !== soll) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, ist, soll);
    end
  endtask

  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (RAMLesenAn || RAMSchreibenAn) begin
        if (!ramNie && ramWarte >= ramLatenz) begin
          if (RAMSchreibenAn) begin
            ramMem[RAMAdresse]  = RAMDatenRein;
            RAMDatenGeschrieben = 1'b1;
          end else begin
            RAMDatenRaus   = ramMem[RAMAdresse];
            RAMDatenBereit = 1'b1;
          end
        end else begin
          RAMDatenBereit      = 1'b0;
          RAMDatenGeschrieben = 1'b0;
        end
        ramWarte++;
      end else begin
        ramWarte            = 0;
        RAMDatenBereit      = 1'b0;
        RAMDatenGeschrieben = 1'b0;
      end
    end
  end

  task automatic doReset();
    Reset           = 1'b0;
    LeseInstruktion = 1'b0;
    LeseDaten       = 1'b0;
    SchreibeDaten   = 1'b0;
    repeat (2) tick();
    Reset             = 1'b1;
    modelLetzterDaten = 1'b1;
    refIO             = '0;
  endtask

  // Waits for the next done pulse; typ 0 fetch, 1 data read, 2 data write, 9 several.
  task automatic warteDone(output int typ, output int n, output int cmdN,
                           output logic [7:0] adr, output logic fe, output logic [31:0] wert);
    int anz;
    typ = -1; n = 0; cmdN = 0; adr = '0; fe = 1'b0; wert = '0;
    while (typ < 0 && n < 60) begin
      tick();
      n++;
      if (RAMLesenAn || RAMSchreibenAn) begin
        if (cmdN == 0) adr = RAMAdresse;
        cmdN++;
      end
      anz = int'(InstruktionGeladen) + int'(DatenGeladen) + int'(DatenGespeichert);
      if (anz > 1)                 typ = 9;
      else if (InstruktionGeladen) typ = 0;
      else if (DatenGeladen)       typ = 1;
      else if (DatenGespeichert)   typ = 2;
    end
    if (typ < 0) begin
      tests++;
      fails++;
      $display("FAIL done wait: got no done pulse within %0d cycles, expected one", n);
    end else begin
      fe   = Fehler;
      wert = (typ == 0) ? Instruktion : DatenRein;
      if (typ == 0 || typ == 9) LeseInstruktion = 1'b0;
      if (typ != 0) begin
        LeseDaten     = 1'b0;
        SchreibeDaten = 1'b0;
      end
    end
  endtask

  int          typ, n, cmdN, puls;
  logic [7:0]  adrSeen;
  logic        fe;
  logic [31:0] wert;

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ramMem[i] = $urandom;
    ramMem[8'h05] = 32'hDEADBEEF;
    ramMem[8'hFF] = 32'h0BADF00D;
    for (int i = 0; i < 256; i++) refMem[i] = ramMem[i];

    //            instr lies schr adr            wdat          lat ioIn   typ n  cmd wert          fe    io
    vek[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0,         0, 8'h00, 0, 2, 1, 32'hDEADBEEF, 1'b0, 8'h00};
    vek[1] = '{1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h12345678,  0, 8'h00, 2, 1, 0, 32'h0,        1'b0, 8'h78};
    vek[2] = '{1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0,         0, 8'hA5, 1, 1, 0, 32'h000000A5, 1'b0, 8'h78};
    vek[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,        -1, 8'h00, 1, 5, 4, 32'h0,        1'b1, 8'h78};
    vek[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hCAFEF00D,  2, 8'h00, 2, 4, 3, 32'h0,        1'b0, 8'h78};
    vek[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1, 8'h00, 1, 3, 2, 32'hCAFEF00D, 1'b0, 8'h78};
    vek[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0033, 32'h0,        -1, 8'h00, 0, 5, 4, 32'h0,        1'b1, 8'h78};
    vek[7] = '{1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h11112222, -1, 8'h00, 2, 5, 4, 32'h0,        1'b1, 8'h78};
    vek[8] = '{1'b1, 1'b0, 1'b0, 32'h0000_01FF, 32'h0,         3, 8'h00, 0, 5, 4, 32'h0BADF00D, 1'b0, 8'h78};

    // Reset state
    doReset();
    pruefe("reset InstruktionGeladen", 32'(InstruktionGeladen), 32'd0);
    pruefe("reset DatenGeladen", 32'(DatenGeladen), 32'd0);
    pruefe("reset DatenGespeichert", 32'(DatenGespeichert), 32'd0);
    pruefe("reset Fehler", 32'(Fehler), 32'd0);
    pruefe("reset RAMLesenAn", 32'(RAMLesenAn), 32'd0);
    pruefe("reset RAMSchreibenAn", 32'(RAMSchreibenAn), 32'd0);
    pruefe("reset RAMAdresse", 32'(RAMAdresse), 32'd0);
    pruefe("reset RAMDatenRein", RAMDatenRein, 32'd0);
    pruefe("reset Instruktion", Instruktion, 32'd0);
    pruefe("reset DatenRein", DatenRein, 32'd0);
    pruefe("reset IOAusgabe", 32'(IOAusgabe), 32'd0);

    // Directed vector table, one requester at a time
    for (int i = 0; i < 9; i++) begin
      IOEingang = vek[i].ioIn;
      ramNie    = (vek[i].lat < 0);
      ramLatenz = vek[i].lat;
      if (vek[i].instr) begin
        InstruktionAdresse = vek[i].adr;
        LeseInstruktion    = 1'b1;
      end else begin
        DatenAdresse  = vek[i].adr;
        DatenRaus     = vek[i].wdat;
        LeseDaten     = vek[i].lies;
        SchreibeDaten = vek[i].schreib;
      end
      warteDone(typ, n, cmdN, adrSeen, fe, wert);
      pruefe($sformatf("vek%0d done type", i), 32'(typ), 32'(vek[i].expTyp));
      pruefe($sformatf("vek%0d done cycle", i), 32'(n), 32'(vek[i].expN));
      pruefe($sformatf("vek%0d command cycles", i), 32'(cmdN), 32'(vek[i].expCmd));
      pruefe($sformatf("vek%0d Fehler", i), 32'(fe), 32'(vek[i].expFe));
      pruefe($sformatf("vek%0d IOAusgabe", i), 32'(IOAusgabe), 32'(vek[i].expIO));
      if (vek[i].expTyp != 2) pruefe($sformatf("vek%0d result", i), wert, vek[i].expWert);
      if (vek[i].expCmd > 0) pruefe($sformatf("vek%0d RAMAdresse", i), 32'(adrSeen), 32'(vek[i].adr[AB-1:0]));
      if (vek[i].expTyp == 2 && vek[i].expCmd > 0 && !vek[i].expFe) refMem[vek[i].adr[AB-1:0]] = vek[i].wdat;
      refIO = vek[i].expIO;
      tick();
    end

    // Both after reset: fetch first, held data read granted right after FERTIG
    doReset();
    ramNie = 1'b0; ramLatenz = 0;
    InstruktionAdresse = 32'h1; DatenAdresse = 32'h2;
    LeseInstruktion = 1'b1; LeseDaten = 1'b1;
    warteDone(typ, n, cmdN, adrSeen, fe, wert);
    pruefe("arb1 first type", 32'(typ), 32'd0);
    pruefe("arb1 first cycle", 32'(n), 32'd2);
    pruefe("arb1 first data", wert, refMem[1]);
    warteDone(typ, n, cmdN, adrSeen, fe, wert);
    pruefe("arb1 second type", 32'(typ), 32'd1);
    pruefe("arb1 second cycle", 32'(n), 32'd3);
    pruefe("arb1 second address", 32'(adrSeen), 32'h2);
    pruefe("arb1 second data", wert, refMem[2]);
    tick();

    // After a fetch, both raised again: data goes first, then fetch
    doReset();
    LeseInstruktion = 1'b1; LeseDaten = 1'b1;
    warteDone(typ, n, cmdN, adrSeen, fe, wert);
    pruefe("arb2 first type", 32'(typ), 32'd0);
    LeseDaten = 1'b0;
    tick();
    LeseInstruktion = 1'b1; LeseDaten = 1'b1;
    warteDone(typ, n, cmdN, adrSeen, fe, wert);
    pruefe("arb2 second type", 32'(typ), 32'd1);
    pruefe("arb2 second cycle", 32'(n), 32'd2);
    warteDone(typ, n, cmdN, adrSeen, fe, wert);
    pruefe("arb2 third type", 32'(typ), 32'd0);
    pruefe("arb2 third cycle", 32'(n), 32'd3);
    tick();

    // Reset asserted while a RAM write is pending
    doReset();
    ramNie = 1'b1;
    DatenAdresse = 32'h11; DatenRaus = 32'h55AA55AA; SchreibeDaten = 1'b1;
    tick();
    pruefe("rst write command up", 32'(RAMSchreibenAn), 32'd1);
    #2 Reset = 1'b0;
    #1;
    pruefe("rst write command drop", 32'(RAMSchreibenAn), 32'd0);
    SchreibeDaten = 1'b0;
    puls = 0;
    repeat (3) begin
      tick();
      puls += int'(DatenGespeichert);
    end
    pruefe("rst no DatenGespeichert", 32'(puls), 32'd0);
    Reset = 1'b1;
    modelLetzterDaten = 1'b1;
    refIO = '0;
    ramNie = 1'b0; ramLatenz = 1;
    LeseInstruktion = 1'b1; LeseDaten = 1'b1;
    warteDone(typ, n, cmdN, adrSeen, fe, wert);
    pruefe("rst first grant type", 32'(typ), 32'd0);
    warteDone(typ, n, cmdN, adrSeen, fe, wert);
    pruefe("rst second grant type", 32'(typ), 32'd1);
    tick();

    // Random rounds against the transaction-level model
    doReset();
    for (int r = 0; r < 150; r++) begin
      bit          rI, rD, io, schreib, nie, erster, wer;
      int          lat, expTyp, expLat;
      logic [31:0] adrI, adrD, wdat, expWert;
      logic [7:0]  ioIn;
      bit          expFe;
      rI      = 1'($urandom_range(0, 1));
      rD      = 1'($urandom_range(0, 1));
      if (!rI && !rD) rD = 1'b1;
      io      = ($urandom_range(0, 3) == 0);
      schreib = 1'($urandom_range(0, 1));
      nie     = ($urandom_range(0, 5) == 0);
      lat     = int'($urandom_range(0, 3));
      adrI    = $urandom;
      adrD    = $urandom;
      adrD[31] = io;
      wdat    = $urandom;
      ioIn    = 8'($urandom_range(0, 255));
      ramNie = nie; ramLatenz = lat; IOEingang = ioIn;
      InstruktionAdresse = adrI; DatenAdresse = adrD; DatenRaus = wdat;
      LeseInstruktion = rI;
      SchreibeDaten   = rD && schreib;
      LeseDaten       = rD && (!schreib || 1'($urandom_range(0, 1)));
      erster = (rI && rD) ? !modelLetzterDaten : rD;
      for (int k = 0; k < int'(rI) + int'(rD); k++) begin
        wer = (k == 0) ? erster : !erster;
        expFe = 1'b0; expWert = '0;
        if (!wer) begin
          expTyp  = 0;
          expLat  = nie ? TO + 1 : lat + 2;
          expFe   = nie;
          expWert = nie ? 32'h0 : refMem[adrI[AB-1:0]];
        end else if (io) begin
          expTyp = schreib ? 2 : 1;
          expLat = 1;
          expWert = {24'b0, ioIn};
          if (schreib) refIO = wdat[7:0];
        end else begin
          expTyp  = schreib ? 2 : 1;
          expLat  = nie ? TO + 1 : lat + 2;
          expFe   = nie;
          expWert = nie ? 32'h0 : refMem[adrD[AB-1:0]];
          if (schreib && !nie) refMem[adrD[AB-1:0]] = wdat;
        end
        warteDone(typ, n, cmdN, adrSeen, fe, wert);
        pruefe($sformatf("rnd%0d.%0d type", r, k), 32'(typ), 32'(expTyp));
        pruefe($sformatf("rnd%0d.%0d cycle", r, k), 32'(n), 32'(expLat + k));
        pruefe($sformatf("rnd%0d.%0d Fehler", r, k), 32'(fe), 32'(expFe));
        pruefe($sformatf("rnd%0d.%0d IOAusgabe", r, k), 32'(IOAusgabe), 32'(refIO));
        if (expTyp != 2) pruefe($sformatf("rnd%0d.%0d result", r, k), wert, expWert);
        modelLetzterDaten = wer;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/speicher_arbiter.md
# speicher_arbiter

Shares one single-port RAM between the CPU instruction-fetch port and the CPU data port, and decodes the memory-mapped I/O window (data address bit 31 set) so I/O accesses never reach the RAM. It sits between the CPU and a unified program/data RAM. It replaces the separate instruction and data RAM pair and the ad-hoc LED write decode in the top level. Every access uses a level-request / one-cycle-done handshake and is protected by a response timeout.

## Interface
- ADRESSBREITE, 8: RAM word-address width; RAMAdresse = low ADRESSBREITE bits of the captured CPU address.
- TIMEOUT, 16: maximum RAM wait cycles before forced completion with error. 0 disables the timeout.
- Clock  in  1  single clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- LeseInstruktion  in  1  instruction fetch request (level).
- InstruktionAdresse  in  32  fetch address.
- Instruktion  out  32  fetched word, registered, valid while InstruktionGeladen=1 and held afterwards.
- InstruktionGeladen  out  1  one-cycle fetch done.
- LeseDaten  in  1  data read request (level).
- SchreibeDaten  in  1  data write request (level); wins if asserted together with LeseDaten.
- DatenAdresse  in  32  data address; bit 31 selects I/O.
- DatenRaus  in  32  write data from CPU.
- DatenRein  out  32  read data to CPU, registered.
- DatenGeladen  out  1  one-cycle data-read done.
- DatenGespeichert  out  1  one-cycle data-write done.
- Fehler  out  1  high together with the done pulse when the access timed out.
- RAMLesenAn, RAMSchreibenAn  out  1  RAM commands, registered, held until RAM acknowledges.
- RAMAdresse  out  ADRESSBREITE;  RAMDatenRein  out  32.
- RAMDatenRaus  in  32;  RAMDatenBereit, RAMDatenGeschrieben  in  1  RAM acknowledges.
- IOAusgabe  out  8  I/O output register (LEDs).
- IOEingang  in  8  I/O input, returned zero-extended on I/O reads.

## Operation
- States: RUHE, INSTR, DLESEN, DSCHREIBEN, FERTIG.
- RUHE:
  - Evaluate requests. Instruction and data requests are arbitered round-robin with a last-grant flag; after reset the flag favours instruction.
  - A single pending request is granted without regard to the flag.
  - At grant, capture the address, the write data and the requester ID.
- Data request with address[31]=1 (I/O):
  - No RAM command is issued; go directly to FERTIG.
  - Write: IOAusgabe <= DatenRaus[7:0].
  - Read: DatenRein <= {24'b0, IOEingang}.
- INSTR/DLESEN: RAMLesenAn=1. When RAMDatenBereit=1, capture RAMDatenRaus into Instruktion or DatenRein, drop the command and go to FERTIG.
- DSCHREIBEN: RAMSchreibenAn=1 with RAMDatenRein=captured data. When RAMDatenGeschrieben=1, drop the command and go to FERTIG.
- Timeout counter:
  - Loaded with TIMEOUT at grant; decrements each RAM wait cycle.
  - On reaching 0 without an acknowledge: drop the command, set the result to 32'b0, go to FERTIG with Fehler=1.
- FERTIG (one cycle):
  - Exactly one done output is high; toggle the last-grant flag to the served requester.
  - Unconditionally return to RUHE.
- Requester obligation: request is low in the cycle after its done pulse. FERTIG guarantees the stale request is never re-granted.
- Address or data changes on a port after grant are ignored until its done pulse.
- RAM acknowledge outside INSTR/DLESEN/DSCHREIBEN is ignored.

## Timing
- Reset values: state RUHE, all done outputs 0, Fehler 0, RAM commands 0, RAMAdresse 0, RAMDatenRein 0, Instruktion 0, DatenRein 0, IOAusgabe 0, last-grant flag favours instruction.
- Reset asserted mid-access aborts the access at once: the RAM command drops asynchronously and no done pulse is produced.
- Request seen in cycle 0 (RUHE) -> RAM command high from cycle 1.
- RAM acknowledge in cycle k -> done high in cycle k+1, data valid in cycle k+1.
- Fastest RAM access (acknowledge in cycle 1): done in cycle 2.
- I/O access: done in cycle 1.
- Back-to-back: next grant decision in the cycle after FERTIG, so at most one idle cycle between transactions.
- Timeout, with no acknowledge: done with Fehler=1 in cycle TIMEOUT+1 after grant.

## Test plan
- Fetch only, address 0x05, RAM acknowledges 1 cycle after command with 0xDEADBEEF -> RAMAdresse=0x05, InstruktionGeladen pulse in cycle 2, Instruktion=0xDEADBEEF.
- Fetch and data read both requested in the same RUHE cycle after reset -> fetch served first, data read granted in the cycle after fetch FERTIG; then both raised again -> data served first.
- Data write 0x12345678 to 0x80000000 -> no RAM command, IOAusgabe=0x78, DatenGespeichert in cycle 1. Read 0x80000004 with IOEingang=0xA5 -> DatenRein=0x000000A5.
- TIMEOUT=4, RAM never acknowledges a data read -> RAMLesenAn high 4 cycles, DatenGeladen and Fehler high in cycle 5, DatenRein=0.
- Reset driven low while RAMSchreibenAn=1 -> RAMSchreibenAn=0 immediately, no DatenGespeichert; after release, the first grant goes to instruction.
- LeseDaten and SchreibeDaten both high to 0x10 -> RAMSchreibenAn only, DatenGespeichert pulses, DatenGeladen stays 0.
